// File: rtl/uart_prog_loader.sv
// Program loader: receives a framed UART byte stream, assembles little-endian
// 32-bit words and writes them into program ROM while holding the CPU in reset.
module uart_prog_loader #(
   parameter int ADDR_W      = 14,
   parameter int TIMEOUT_CYC = 1_000_000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              prog_mode,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   word_count
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [2:0] {
      ST_IDLE, ST_LEN0, ST_LEN1, ST_DATA, ST_CSUM, ST_DONE, ST_ERR
   } state_t;

   state_t            state_r;
   state_t            state_nxt_s;
   logic [15:0]       len_r;
   logic [1:0]        idx_r;
   logic [23:0]       word_buf_r;
   logic [7:0]        csum_r;
   logic [CNT_W-1:0]  tmo_cnt_r;
   logic              loading_s;
   logic              expire_s;
   logic              word_last_s;
   logic              len_bad_s;
   logic [15:0]       len_full_s;

   assign len_full_s  = {rx_data, len_r[7:0]};
   assign len_bad_s   = (len_full_s == 16'd0) ||
                        (17'(len_full_s) > (17'd1 << ADDR_W));
   assign word_last_s = ((17'(word_count) + 17'd1) == 17'(len_r));
   assign expire_s    = (tmo_cnt_r == CNT_W'(TIMEOUT_CYC - 1));

   // Next-state decode; a received byte always takes priority over timeout expiry.
   always_comb begin
      state_nxt_s = state_r;
      loading_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start) state_nxt_s = ST_LEN0;
            else       state_nxt_s = ST_IDLE;
         end
         ST_LEN0: begin
            loading_s = 1'b1;
            if (rx_valid)      state_nxt_s = ST_LEN1;
            else if (expire_s) state_nxt_s = ST_ERR;
            else               state_nxt_s = ST_LEN0;
         end
         ST_LEN1: begin
            loading_s = 1'b1;
            if (rx_valid)      state_nxt_s = len_bad_s ? ST_ERR : ST_DATA;
            else if (expire_s) state_nxt_s = ST_ERR;
            else               state_nxt_s = ST_LEN1;
         end
         ST_DATA: begin
            loading_s = 1'b1;
            if (rx_valid) begin
               if ((idx_r == 2'd3) && word_last_s) state_nxt_s = ST_CSUM;
               else                                 state_nxt_s = ST_DATA;
            end else if (expire_s) begin
               state_nxt_s = ST_ERR;
            end else begin
               state_nxt_s = ST_DATA;
            end
         end
         ST_CSUM: begin
            loading_s = 1'b1;
            if (rx_valid)      state_nxt_s = (rx_data == csum_r) ? ST_DONE : ST_ERR;
            else if (expire_s) state_nxt_s = ST_ERR;
            else               state_nxt_s = ST_CSUM;
         end
         ST_DONE: state_nxt_s = ST_IDLE;
         ST_ERR:  state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State, registered outputs, word assembly and inter-byte timeout counter.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r    <= ST_IDLE;
         prog_mode  <= 1'b0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= 32'd0;
         done       <= 1'b0;
         err        <= 1'b0;
         word_count <= '0;
         len_r      <= 16'd0;
         idx_r      <= 2'd0;
         word_buf_r <= 24'd0;
         csum_r     <= 8'd0;
         tmo_cnt_r  <= '0;
      end else begin
         state_r   <= state_nxt_s;
         prog_mode <= (state_nxt_s == ST_LEN0) || (state_nxt_s == ST_LEN1) ||
                      (state_nxt_s == ST_DATA) || (state_nxt_s == ST_CSUM);
         done      <= (state_nxt_s == ST_DONE);
         wr_en     <= 1'b0;
         if (!loading_s || rx_valid || (state_nxt_s != state_r)) begin
            tmo_cnt_r <= '0;
         end else begin
            tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
         end
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  err        <= 1'b0;
                  word_count <= '0;
                  idx_r      <= 2'd0;
                  csum_r     <= 8'd0;
               end
            end
            ST_LEN0: if (rx_valid) len_r[7:0]  <= rx_data;
            ST_LEN1: if (rx_valid) len_r[15:8] <= rx_data;
            ST_DATA: begin
               if (rx_valid) begin
                  csum_r <= csum_r ^ rx_data;
                  idx_r  <= idx_r + 2'd1;
                  case (idx_r)
                     2'd0: word_buf_r[7:0]   <= rx_data;
                     2'd1: word_buf_r[15:8]  <= rx_data;
                     2'd2: word_buf_r[23:16] <= rx_data;
                     2'd3: begin
                        wr_data    <= {rx_data, word_buf_r};
                        wr_addr    <= word_count[ADDR_W-1:0];
                        wr_en      <= 1'b1;
                        word_count <= word_count + (ADDR_W+1)'(1);
                     end
                     default: idx_r <= 2'd0;
                  endcase
               end
            end
            default: ;
         endcase
         if (state_nxt_s == ST_ERR) err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed self-checking bench for uart_prog_loader (TIMEOUT_CYC reduced to 16).
module tb_uart_prog_loader;

   localparam int ADDR_W = 14;

   logic              clock;
   logic              reset;
   logic              start;
   logic              rx_valid;
   logic [7:0]        rx_data;
   logic              prog_mode;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [31:0]       wr_data;
   logic              done;
   logic              err;
   logic [ADDR_W:0]   word_count;

   int n_checks = 0;
   int n_fail   = 0;
   int pulses   = 0;

   uart_prog_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(16)) dut (
      .clock(clock), .reset(reset), .start(start), .rx_valid(rx_valid),
      .rx_data(rx_data), .prog_mode(prog_mode), .wr_en(wr_en),
      .wr_addr(wr_addr), .wr_data(wr_data), .done(done), .err(err),
      .word_count(word_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs at a falling edge, advance to the next falling edge.
   task automatic cycle(input logic s, input logic v, input logic [7:0] d);
      start    = s;
      rx_valid = v;
      rx_data  = d;
      @(negedge clock);
      if (wr_en === 1'b1) pulses++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
      repeat (3) @(negedge clock);
      check("rst_prog_mode", prog_mode, 1'b0);
      check("rst_wr_en", wr_en, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_wr_addr", wr_addr, 0);
      check("rst_wr_data", wr_data, 0);
      check("rst_word_count", word_count, 0);
      reset = 1'b1;
      idle(2);

      // Good N=2 load, bytes back-to-back
      pulses = 0;
      cycle(1'b1, 1'b0, 8'h00);
      check("t1_prog_mode_rise", prog_mode, 1'b1);
      cycle(1'b0, 1'b1, 8'h02); cycle(1'b0, 1'b1, 8'h00);
      cycle(1'b0, 1'b1, 8'h13); cycle(1'b0, 1'b1, 8'h00);
      cycle(1'b0, 1'b1, 8'h08); cycle(1'b0, 1'b1, 8'h20);
      check("t1_w0_en", wr_en, 1'b1);
      check("t1_w0_addr", wr_addr, 0);
      check("t1_w0_data", wr_data, 32'h2008_0013);
      cycle(1'b0, 1'b1, 8'h08);
      check("t1_w0_en_drop", wr_en, 1'b0);
      cycle(1'b0, 1'b1, 8'h00); cycle(1'b0, 1'b1, 8'h00); cycle(1'b0, 1'b1, 8'h00);
      check("t1_w1_en", wr_en, 1'b1);
      check("t1_w1_addr", wr_addr, 1);
      check("t1_w1_data", wr_data, 32'h0000_0008);
      check("t1_pm_before_csum", prog_mode, 1'b1);
      cycle(1'b0, 1'b1, 8'h33);
      check("t1_done", done, 1'b1);
      check("t1_prog_mode_fall", prog_mode, 1'b0);
      check("t1_err", err, 1'b0);
      check("t1_word_count", word_count, 2);
      idle(1);
      check("t1_done_one_cycle", done, 1'b0);
      check("t1_pulses", pulses, 2);

      // Bad checksum
      pulses = 0;
      cycle(1'b1, 1'b0, 8'h00);
      cycle(1'b0, 1'b1, 8'h02); cycle(1'b0, 1'b1, 8'h00);
      cycle(1'b0, 1'b1, 8'h13); cycle(1'b0, 1'b1, 8'h00);
      cycle(1'b0, 1'b1, 8'h08); cycle(1'b0, 1'b1, 8'h20);
      cycle(1'b0, 1'b1, 8'h08); cycle(1'b0, 1'b1, 8'h00);
      cycle(1'b0, 1'b1, 8'h00); cycle(1'b0, 1'b1, 8'h00);
      cycle(1'b0, 1'b1, 8'h34);
      check("t2_err", err, 1'b1);
      check("t2_done", done, 1'b0);
      check("t2_prog_mode", prog_mode, 1'b0);
      idle(2);
      check("t2_err_sticky", err, 1'b1);
      check("t2_done_never", done, 1'b0);
      check("t2_pulses", pulses, 2);

      // Illegal lengths: 0 and 2^ADDR_W+1
      pulses = 0;
      cycle(1'b1, 1'b0, 8'h00);
      check("t3_err_cleared", err, 1'b0);
      cycle(1'b0, 1'b1, 8'h00); cycle(1'b0, 1'b1, 8'h00);
      check("t3_len0_err", err, 1'b1);
      check("t3_len0_pm", prog_mode, 1'b0);
      idle(1);
      cycle(1'b1, 1'b0, 8'h00);
      cycle(1'b0, 1'b1, 8'h01); cycle(1'b0, 1'b1, 8'h40);
      check("t3_lenbig_err", err, 1'b1);
      check("t3_lenbig_pm", prog_mode, 1'b0);
      idle(4);
      check("t3_pulses", pulses, 0);

      // Timeout: 16 idle cycles aborts
      cycle(1'b1, 1'b0, 8'h00);
      cycle(1'b0, 1'b1, 8'h01); cycle(1'b0, 1'b1, 8'h00);
      cycle(1'b0, 1'b1, 8'hAA); cycle(1'b0, 1'b1, 8'hBB);
      idle(15);
      check("t4_15_pm", prog_mode, 1'b1);
      check("t4_15_err", err, 1'b0);
      idle(1);
      check("t4_16_err", err, 1'b1);
      check("t4_16_pm", prog_mode, 1'b0);
      idle(1);

      // Timeout: 15 idle cycles then a byte continues
      pulses = 0;
      cycle(1'b1, 1'b0, 8'h00);
      cycle(1'b0, 1'b1, 8'h01); cycle(1'b0, 1'b1, 8'h00);
      cycle(1'b0, 1'b1, 8'hAA); cycle(1'b0, 1'b1, 8'hBB);
      idle(15);
      cycle(1'b0, 1'b1, 8'hCC);
      check("t5_byte_wins_pm", prog_mode, 1'b1);
      check("t5_byte_wins_err", err, 1'b0);
      cycle(1'b0, 1'b1, 8'hDD);
      check("t5_w0_en", wr_en, 1'b1);
      check("t5_w0_data", wr_data, 32'hDDCC_BBAA);
      cycle(1'b0, 1'b1, 8'h00);
      check("t5_done", done, 1'b1);
      check("t5_err", err, 1'b0);
      idle(1);

      // Asynchronous reset mid-load, then reload from address 0
      pulses = 0;
      cycle(1'b1, 1'b0, 8'h00);
      cycle(1'b0, 1'b1, 8'h02); cycle(1'b0, 1'b1, 8'h00);
      cycle(1'b0, 1'b1, 8'h13); cycle(1'b0, 1'b1, 8'h00);
      cycle(1'b0, 1'b1, 8'h08); cycle(1'b0, 1'b1, 8'h20);
      cycle(1'b0, 1'b1, 8'h08);
      check("t6_wc_before", word_count, 1);
      #2 reset = 1'b0;
      #1;
      check("t6_async_pm", prog_mode, 1'b0);
      check("t6_async_wc", word_count, 0);
      check("t6_async_addr", wr_addr, 0);
      check("t6_async_data", wr_data, 0);
      @(negedge clock);
      pulses = 0;
      cycle(1'b0, 1'b1, 8'h00); cycle(1'b0, 1'b1, 8'h00); cycle(1'b0, 1'b1, 8'h00);
      check("t6_no_write_in_reset", pulses, 0);
      reset = 1'b1;
      idle(1);
      cycle(1'b1, 1'b0, 8'h00);
      cycle(1'b0, 1'b1, 8'h02); cycle(1'b0, 1'b1, 8'h00);
      cycle(1'b0, 1'b1, 8'h13); cycle(1'b0, 1'b1, 8'h00);
      cycle(1'b0, 1'b1, 8'h08); cycle(1'b0, 1'b1, 8'h20);
      check("t6_w0_addr", wr_addr, 0);
      check("t6_w0_data", wr_data, 32'h2008_0013);
      cycle(1'b0, 1'b1, 8'h08); cycle(1'b0, 1'b1, 8'h00);
      cycle(1'b0, 1'b1, 8'h00); cycle(1'b0, 1'b1, 8'h00);
      check("t6_w1_addr", wr_addr, 1);
      cycle(1'b0, 1'b1, 8'h33);
      check("t6_done", done, 1'b1);
      idle(1);

      // Streaming with a second start mid-load
      pulses = 0;
      cycle(1'b1, 1'b0, 8'h00);
      cycle(1'b0, 1'b1, 8'h02); cycle(1'b0, 1'b1, 8'h00);
      cycle(1'b0, 1'b1, 8'h11); cycle(1'b1, 1'b1, 8'h22);
      check("t7_restart_ignored_pm", prog_mode, 1'b1);
      cycle(1'b0, 1'b1, 8'h33); cycle(1'b0, 1'b1, 8'h44);
      check("t7_w0_addr", wr_addr, 0);
      check("t7_w0_data", wr_data, 32'h4433_2211);
      cycle(1'b0, 1'b1, 8'h55); cycle(1'b1, 1'b1, 8'h66);
      cycle(1'b0, 1'b1, 8'h77); cycle(1'b0, 1'b1, 8'h88);
      check("t7_w1_addr", wr_addr, 1);
      check("t7_w1_data", wr_data, 32'h8877_6655);
      cycle(1'b0, 1'b1, 8'h88);
      check("t7_done", done, 1'b1);
      check("t7_err", err, 1'b0);
      check("t7_word_count", word_count, 2);
      idle(2);
      check("t7_pulses", pulses, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
